// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: baud_tick-enabled byte UART transmitter (8N1 default),
// optional odd/even parity, 1 or 2 stop bits, one-entry holding register.
module uart_tx_serializer #(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_slow,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int   PAR_EFF   = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
    localparam int   STOP_EFF  = (STOP_BITS == 2) ? 2 : 1;
    localparam logic PAR_ON    = (PAR_EFF != 0);
    localparam logic PAR_ODD   = (PAR_EFF == 1);
    localparam logic LAST_STOP = (STOP_EFF == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    logic [7:0] r_hold_data;
    logic       r_hold_full;
    logic [7:0] r_shift;
    logic       r_par;
    logic [2:0] r_bit_cnt;
    logic       r_stop_cnt;
    logic       r_tx;
    logic       r_tx_done;

    state_t     w_state_nxt;
    logic [7:0] w_hold_data_nxt;
    logic       w_hold_full_nxt;
    logic [7:0] w_shift_nxt;
    logic       w_par_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic       w_stop_cnt_nxt;
    logic       w_tx_nxt;
    logic       w_tx_done_nxt;
    logic       w_load;
    logic       w_accept;

    assign w_accept   = data_valid && !r_hold_full;
    assign data_ready = !r_hold_full;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign tx_done    = r_tx_done;

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold_data <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_stop_cnt  <= 1'b0;
            r_tx        <= 1'b1;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_data <= w_hold_data_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_shift     <= w_shift_nxt;
            r_par       <= w_par_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_stop_cnt  <= w_stop_cnt_nxt;
            r_tx        <= w_tx_nxt;
            r_tx_done   <= w_tx_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_data_nxt = r_hold_data;
        w_hold_full_nxt = r_hold_full;
        w_shift_nxt     = r_shift;
        w_par_nxt       = r_par;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_stop_cnt_nxt  = r_stop_cnt;
        w_tx_nxt        = r_tx;
        w_tx_done_nxt   = 1'b0;
        w_load          = 1'b0;

        if (w_accept) begin
            w_hold_data_nxt = data_in;
            w_hold_full_nxt = 1'b1;
        end

        if (baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_load = r_hold_full;
                end
                S_START: begin
                    w_tx_nxt      = r_shift[0];
                    w_bit_cnt_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                end
                S_DATA: begin
                    if (r_bit_cnt != 3'd7) begin
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end else if (PAR_ON) begin
                        w_tx_nxt    = r_par;
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_tx_nxt       = 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                        w_state_nxt    = S_STOP;
                    end
                end
                S_PARITY: begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
                S_STOP: begin
                    if (r_stop_cnt != LAST_STOP) begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end else begin
                        w_tx_done_nxt = 1'b1;
                        w_load        = r_hold_full;
                        if (!r_hold_full) begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Load never coincides with accept: accept needs an empty holder.
        if (w_load) begin
            w_tx_nxt        = 1'b0;
            w_shift_nxt     = r_hold_data;
            w_hold_full_nxt = 1'b0;
            w_par_nxt       = (^r_hold_data) ^ PAR_ODD;
            w_state_nxt     = S_START;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: three parity/stop configurations,
// directed frames plus randomized ticks, data, valid and resets.
module tb_uart_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    task automatic chk(input string nm, input int g, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d want %0d at %0t", nm, g, act, exp, $time);
        end
    endtask

    // Expected line level of bit i of a frame carrying byte b.
    function automatic int bitv(input logic [7:0] b, input int i, input int p);
        if (i == 0) return 0;
        if (i <= 8) return int'(b[i-1]);
        if (i == 9 && p != 0) return (p == 2) ? int'(^b) : int'(~^b);
        return 1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int G = g;
        localparam int P = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int S = (g == 0) ? 1 : 2;
        localparam int FLEN = 9 + ((P != 0) ? 1 : 0) + S;

        logic       rst  = 1'b1;
        logic       tick = 1'b1;
        logic [7:0] din  = 8'h00;
        logic       dv   = 1'b0;
        logic       dr;
        logic       tx;
        logic       busy;
        logic       done;

        logic [7:0] q[$];
        int         mcnt   = 0;
        int         tmode  = 0;
        int         tcnt   = 0;
        logic [7:0] cur    = 8'h00;
        logic       rst_s  = 1'b1;
        logic       tick_s = 1'b0;
        logic       prev_tx = 1'b1;

        uart_tx_serializer #(.PARITY(P), .STOP_BITS(S)) u_dut (
            .clk_slow  (clk),
            .rst       (rst),
            .baud_tick (tick),
            .data_in   (din),
            .data_valid(dv),
            .data_ready(dr),
            .tx        (tx),
            .busy      (busy),
            .tx_done   (done)
        );

        always @(posedge clk) begin
            rst_s  = rst;
            tick_s = tick;
        end

        always @(negedge clk) begin
            if (rst_s) begin
                mcnt = 0;
                chk("rst_tx", G, tx, 1);
                chk("rst_busy", G, busy, 0);
                chk("rst_ready", G, dr, 1);
                chk("rst_done", G, done, 0);
            end else if (tick_s) begin
                if (mcnt != 0 && mcnt == FLEN) begin
                    chk("tx_done_pulse", G, done, 1);
                    mcnt = 0;
                end else begin
                    chk("tx_done_quiet", G, done, 0);
                end
                if (mcnt != 0) begin
                    chk("frame_bit", G, tx, bitv(cur, mcnt, P));
                    chk("busy_in_frame", G, busy, 1);
                    mcnt++;
                end else if (tx == 1'b0) begin
                    chk("frame_expected", G, int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        chk("start_bit", G, tx, bitv(cur, 0, P));
                        chk("busy_at_start", G, busy, 1);
                        mcnt = 1;
                    end
                end else begin
                    chk("busy_idle", G, busy, 0);
                end
            end else begin
                chk("tx_stable", G, tx, prev_tx);
                chk("done_no_tick", G, done, 0);
                chk("busy_no_tick", G, busy, int'(mcnt != 0));
            end
            prev_tx = tx;
        end

        task automatic step();
            @(negedge clk);
            tcnt++;
            case (tmode)
                0:       tick = 1'b1;
                1:       tick = (tcnt % 4 == 0);
                default: tick = ($urandom_range(0, 2) == 0);
            endcase
        endtask

        task automatic send(input logic [7:0] b);
            dv  = 1'b1;
            din = b;
            for (int n = 0; n < 2000 && !dr; n++) step();
            chk("ready_wait", G, dr, 1);
            if (dr) q.push_back(b);
            step();
            dv = 1'b0;
        endtask

        task automatic wait_idle();
            int n;
            for (n = 0; n < 5000; n++) begin
                if (q.size() == 0 && mcnt == 0 && !busy && dr) break;
                step();
            end
            chk("idle_wait", G, int'(n < 5000), 1);
        endtask

        initial begin : prod
            logic r;
            repeat (3) step();
            rst = 1'b0;
            send(8'hA5);
            wait_idle();
            tmode = 1;
            send(8'h00);
            wait_idle();
            tmode = 0;
            send(8'h07);
            wait_idle();
            send(8'h55);
            send(8'hAA);
            wait_idle();
            send(8'hFF);
            for (int n = 0; n < 200 && !busy; n++) step();
            chk("busy_rise", G, busy, 1);
            repeat (4) step();
            rst = 1'b1;
            step();
            q.delete();
            rst = 1'b0;
            wait_idle();
            send(8'h81);
            wait_idle();
            tmode = 2;
            for (int n = 0; n < 4000; n++) begin
                r   = ($urandom_range(0, 399) == 0);
                rst = r;
                dv  = ($urandom_range(0, 1) == 1);
                din = 8'($urandom);
                if (dv && dr && !rst) q.push_back(din);
                step();
                if (r) q.delete();
            end
            rst = 1'b0;
            dv  = 1'b0;
            wait_idle();
            chk("queue_drained", G, q.size(), 0);
            ndone++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && ndone < 3; i++) @(posedge clk);
        chk("all_done", 0, ndone, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-wide UART transmitter that sits directly downstream of the baud rate generator. It consumes the generator's one-cycle baud tick as a clock enable and serializes bytes onto the `tx` line toward the Arduino: 8N1 by default, with optional parity and two stop bits. A one-entry holding register with a valid/ready handshake lets the counter/DRAM logic queue the next byte while the current frame shifts out, so consecutive frames go out with no idle bit between them.

## Interface
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even; any other value is treated as 0.
- `STOP_BITS`, default 1: 1 or 2; any other value is treated as 1.
- `clk_slow`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `baud_tick`  input  1  bit-period enable from the baud generator; may be held high (one bit per clock).
- `data_in`  input  8  byte to transmit; sampled on acceptance.
- `data_valid`  input  1  producer has a byte.
- `data_ready`  output  1  holding register empty; a byte is accepted when `data_valid && data_ready`.
- `tx`  output  1  serial line, idle high, LSB first; driven from a register.
- `busy`  output  1  high whenever the state is not IDLE.
- `tx_done`  output  1  one-cycle pulse on the clock where the final stop bit completes.

## Operation
- Holding register: on an accept clock, `hold_data <= data_in` and `hold_full <= 1`. `data_ready = !hold_full` is combinational from the registered flag. Acceptance does not depend on `baud_tick`.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP. It advances only on clocks where `baud_tick = 1`; on all other clocks every register except the holding register holds its value.
- IDLE, tick, and `hold_full`:
  - `tx <= 0`, `shift <= hold_data`, `hold_full <= 0`.
  - Parity register is loaded with the XOR of `hold_data` (inverted for odd parity).
  - Next state is START.
- START, tick: `tx <= shift[0]`, `bit_cnt <= 0`, next state DATA.
- DATA, tick:
  - If `bit_cnt < 7`: shift right, `tx <=` next bit, `bit_cnt++`.
  - If `bit_cnt = 7` and parity is enabled: `tx <=` parity bit, next state PARITY.
  - If `bit_cnt = 7` and parity is disabled: `tx <= 1`, `stop_cnt <= 0`, next state STOP.
- PARITY, tick: `tx <= 1`, `stop_cnt <= 0`, next state STOP.
- STOP, tick, not the last stop bit: `stop_cnt++`, `tx` stays 1.
- STOP, tick, last stop bit:
  - `tx_done <= 1` for one clock.
  - If `hold_full`: perform the IDLE-load actions and go directly to START (back-to-back frame).
  - Otherwise: go to IDLE, `tx` stays 1.
- Frame length is 1 + 8 + (PARITY ? 1 : 0) + STOP_BITS tick intervals.
- Same-clock load and accept cannot happen: `data_ready` is 0 whenever `hold_full` is 1, so no new byte can land in the holding register on the clock it is loaded into the shifter. The earliest new acceptance is the clock after the load.
- `data_valid` while `data_ready = 0`: ignored. The producer must hold `data_valid` until it sees `data_ready`.
- Reset mid-frame: on the next edge `tx = 1`, state IDLE, holding register emptied, and any frame in progress is abandoned without a `tx_done`.

## Timing
- Reset values: `tx = 1`, `busy = 0`, `data_ready = 1`, `tx_done = 0`, `hold_full = 0`, `bit_cnt = 0`, `stop_cnt = 0`.
- Accept to `data_ready` low: 1 clock.
- Accept to start bit on `tx`: the edge of the first tick strictly after the accept clock. With `baud_tick` held high, that is 2 clocks after the accept edge.
- Each bit is held on `tx` from one tick edge to the next tick edge.
- `busy` rises on the same edge the start bit appears and falls on the edge the final stop bit completes, when no byte is pending.
- `tx_done` is asserted on that same edge.

## Test plan
- Reset with `baud_tick = 1`, send 0xA5 (PARITY 0, STOP_BITS 1) → `tx` sequence from the start edge is 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), `tx_done` pulses once, `busy` is high for 10 clocks.
- `baud_tick` high every 4th clock, send 0x00 → each bit is held exactly 4 clocks, the frame lasts 40 clocks, and `tx` never glitches between ticks.
- PARITY = 2, STOP_BITS = 2, send 0x07 → bits 0,1,1,1,0,0,0,0,0 then parity 1, then stop 1,1; total 12 ticks. Repeat with PARITY = 1 → parity bit 0.
- Offer 0x55 then 0xAA back-to-back with `data_valid` held high → 0xAA is accepted while 0x55 is shifting, the 0xAA start bit directly follows the 0x55 stop bit (no idle tick), `tx_done` pulses twice, `busy` never drops between frames.
- Assert `rst` for one clock during data bit 3 of 0xFF → `tx = 1`, `busy = 0`, `data_ready = 1` on the next edge, no `tx_done`; a following send of 0x81 transmits correctly.
- `data_valid` held high with a changing `data_in` while `data_ready = 0` → only the byte present on each accept clock is transmitted; no byte is duplicated or dropped.
